// File: rtl/multicycle_control.sv
// Multi-cycle control path for the MIPS subset: sequences fetch/decode/execute/memory/write-back,
// with ready-handshake or fixed-latency memory waits, illegal-opcode halt and a retired counter.
module multicycle_control #(
  parameter bit USE_READY = 1'b1,
  parameter int MEM_LAT   = 1,
  parameter int CNT_W     = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       op,
  input  logic [5:0]       fun,
  input  logic             equal,
  input  logic             sign,
  input  logic             mem_ready,
  output logic             IRWr,
  output logic             PCWr,
  output logic             nPC_sel,
  output logic             RegWr,
  output logic             RegDst,
  output logic             ExtOp,
  output logic             ALUSrc,
  output logic [2:0]       ALUctr,
  output logic             MemRd,
  output logic             MemWr,
  output logic             MemToReg,
  output logic             halt,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_BRANCH, S_HALT
  } state_t;

  localparam logic [3:0] LAT_LAST = 4'(MEM_LAT - 1);

  state_t     state, state_nxt;
  logic [5:0] op_q, fun_q;
  logic [3:0] wait_cnt;
  logic       access, done, retire;
  logic [3:0] r_live, r_lat;
  logic       legal, is_branch_live;
  logic       is_rtype, is_addi, is_lw, is_sw, taken;

  // {legal, ALUctr} for an R-type funct field
  function automatic logic [3:0] r_decode(input logic [5:0] f);
    case (f)
      6'h20:   return {1'b1, 3'd2};
      6'h21:   return {1'b1, 3'd4};
      6'h22:   return {1'b1, 3'd6};
      6'h23:   return {1'b1, 3'd6};
      6'h24:   return {1'b1, 3'd0};
      6'h25:   return {1'b1, 3'd1};
      6'h00:   return {1'b1, 3'd5};
      6'h2A:   return {1'b1, 3'd3};
      6'h2B:   return {1'b1, 3'd7};
      default: return 4'b0000;
    endcase
  endfunction

  always_comb begin
    r_live         = r_decode(fun);
    r_lat          = r_decode(fun_q);
    is_branch_live = (op inside {6'h04, 6'h05, 6'h07});
    legal          = (op == 6'h00) ? r_live[3]
                                   : (op inside {6'h08, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h07});
    is_rtype       = (op_q == 6'h00);
    is_addi        = (op_q == 6'h08);
    is_lw          = (op_q == 6'h23);
    is_sw          = (op_q == 6'h2B);
    case (op_q)
      6'h04:   taken = equal;
      6'h05:   taken = !equal;
      default: taken = !(equal | sign);
    endcase
    access = (state == S_FETCH) || (state == S_MEM);
    done   = USE_READY ? mem_ready : (wait_cnt == LAT_LAST);
    retire = (state == S_WB) || (state == S_BRANCH) || ((state == S_MEM) && is_sw && done);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_FETCH;
      wait_cnt <= 4'd0;
      retired  <= '0;
      op_q     <= 6'd0;
      fun_q    <= 6'd0;
    end else begin
      state <= state_nxt;
      if (!USE_READY && access && !done) wait_cnt <= wait_cnt + 4'd1;
      else                               wait_cnt <= 4'd0;
      if (retire) retired <= retired + {{(CNT_W-1){1'b0}}, 1'b1};
      if (state == S_DECODE) begin
        op_q  <= op;
        fun_q <= fun;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    IRWr      = 1'b0;
    PCWr      = 1'b0;
    nPC_sel   = 1'b0;
    RegWr     = 1'b0;
    RegDst    = 1'b0;
    ExtOp     = 1'b0;
    ALUSrc    = 1'b0;
    ALUctr    = 3'd0;
    MemRd     = 1'b0;
    MemWr     = 1'b0;
    MemToReg  = 1'b0;
    halt      = 1'b0;
    case (state)
      S_FETCH: begin
        MemRd = 1'b1;
        if (done) begin
          IRWr      = 1'b1;
          PCWr      = 1'b1;
          state_nxt = S_DECODE;
        end
      end
      S_DECODE: begin
        if (!legal)              state_nxt = S_HALT;
        else if (is_branch_live) state_nxt = S_BRANCH;
        else                     state_nxt = S_EXEC;
      end
      S_EXEC, S_MEM, S_WB: begin
        // datapath selects stay valid through the access and the register write
        ExtOp  = is_addi | is_lw | is_sw;
        ALUSrc = is_addi | is_lw | is_sw;
        RegDst = is_rtype;
        ALUctr = is_rtype ? r_lat[2:0] : 3'd2;
        if (state == S_EXEC) begin
          state_nxt = (is_lw || is_sw) ? S_MEM : S_WB;
        end else if (state == S_MEM) begin
          MemRd = is_lw;
          MemWr = is_sw;
          if (done) state_nxt = is_lw ? S_WB : S_FETCH;
        end else begin
          RegWr     = 1'b1;
          MemToReg  = is_lw;
          state_nxt = S_FETCH;
        end
      end
      S_BRANCH: begin
        ALUctr    = 3'd6;
        PCWr      = taken;
        nPC_sel   = taken;
        state_nxt = S_FETCH;
      end
      S_HALT:  halt = 1'b1;
      default: state_nxt = S_FETCH;
    endcase
    // strobes stay quiet while reset is held, whatever state is being left
    if (rst) begin
      IRWr  = 1'b0;
      PCWr  = 1'b0;
      RegWr = 1'b0;
      MemRd = 1'b0;
      MemWr = 1'b0;
    end
  end

endmodule
